mem_arb: RTL and testbench
==========================

# mem_arb

Byte-serial main-memory controller and arbiter, the parametrised successor of the single-word memory controller. It sits between the core (instruction-fetch unit and load/store buffer) and the 8-bit external RAM/IO port. It fetches whole cache lines of `LINE_BYTES` for the I-cache and serves 1/2/4-byte loads and stores for the LSB. Arbitration is LSB-priority with a starvation bound, and the block supports flush abort and an optional IO back-pressure guard.

## Interface
- `LINE_BYTES`, 16: bytes per instruction-fetch burst; power of two, 4..64.
- `ADDR_W`, 32: address width of client and memory address buses.
- `LS_STREAK`, 4: maximum consecutive LSB grants while `if_req` waits.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global ready; low freezes the block.
- `flush` in 1: mispredict flush; aborts abortable reads.
- `if_req` in 1: fetch request; held until `if_done` or flush.
- `if_addr` in ADDR_W: line base address, aligned to `LINE_BYTES`.
- `if_done` out 1: one-cycle pulse; `if_data` valid.
- `if_data` out 8*LINE_BYTES: line, byte i at bits [8i+7:8i].
- `ls_req` in 1: LSB request; held until `ls_done` or flush.
- `ls_we` in 1: 1 = store.
- `ls_size` in 2: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is reserved and treated as 4 bytes.
- `ls_addr` in ADDR_W: start address.
- `ls_wdata` in 32: store data, little-endian.
- `ls_done` out 1: one-cycle pulse; load data valid or store completed.
- `ls_rdata` out 32: load data, zero-extended; sign extension is done by the LSB.
- `mem_din` in 8: RAM read data; reflects the previous cycle's `mem_a`.
- `mem_dout` out 8: write data.
- `mem_a` out ADDR_W: byte address.
- `mem_wr` out 1: 1 = write this cycle.
- `io_buffer_full` in 1: IO output FIFO full.

## Operation
- FSM states are IDLE, IF_RD, LS_RD, LS_WR and DONE. Byte counter `cnt` is log2(LINE_BYTES)+1 bits.
- Request length: n = LINE_BYTES for IF_RD; n = 1/2/4 per `ls_size` for LSB accesses.
- IDLE grant order:
  - `ls_req` wins over `if_req`.
  - If `if_req` has been pending across `LS_STREAK` consecutive LSB grants, IF wins the next grant and the streak counter clears.
  - The streak counter also clears on every IF grant.
- At grant, latch address, size and write data; set `cnt` = 0.
- Reads (IF_RD, LS_RD):
  - `mem_a` = base + cnt while cnt < n.
  - For cnt ≥ 1, `mem_din` is byte cnt−1 and is captured at the clock edge.
  - After capturing byte n−1, go to DONE.
- Writes (LS_WR):
  - `mem_wr` = 1, `mem_a` = base + cnt, `mem_dout` = wdata byte cnt.
  - After byte n−1, go to DONE.
- DONE:
  - Pulse the matching done output for exactly one cycle.
  - Hold `if_data`/`ls_rdata` stable until the next completion of that client.
  - Return to IDLE; no grant is made in DONE.
- Address arithmetic: base + cnt is modulo 2^ADDR_W with no carry checks. Lines never cross alignment.
- In IDLE and DONE: `mem_a` = 0, `mem_wr` = 0, `mem_dout` = 0, so the design never issues a spurious IO read with side effects.
- Flush:
  - In IF_RD or LS_RD: return to IDLE at the next edge with no done pulse.
  - LS_WR is never aborted.
  - A done pulse already being driven is not cancelled.
  - A flush coincident with the final capture cycle aborts; no done is issued.
- Reset (any time, including mid-burst): state IDLE, `cnt` 0, streak 0. All outputs 0, including `if_data` and `ls_rdata`.

## Timing
- Request sampled in IDLE at edge E0. Read done is high in cycle E(n+1)→E(n+2); write done in cycle En→E(n+1).
- Line fetch with LINE_BYTES = 16: grant to `if_done` is 17 cycles. Word load: 5 cycles. Word store: 4 cycles.
- Minimum gap between back-to-back grants: 1 cycle (DONE).
- `rdy` low:
  - No state or register update.
  - `mem_wr` forced 0.
  - In reads with cnt ≥ 1, `mem_a` re-drives base + cnt − 1, so `mem_din` is realigned on the first `rdy`-high cycle.
  - Writes resume the same byte.
- `flush` and `rdy` low in the same cycle: the flush is ignored. The client must re-assert `flush` while `rdy` is high.

## Configuration
- `MEM_IO_GUARD_EN`. IO region is `addr[17:16]` == 2'b11.
- Defined:
  - An LSB store to the IO region is not granted while `io_buffer_full` = 1. Its request waits in IDLE, and IF may be granted meanwhile without advancing the streak counter.
  - LS_RD to the IO region is not abortable by flush, because IO loads are issued only at commit.
- Undefined: `io_buffer_full` is ignored and all LS_RD accesses are abortable.

## Test plan
- Reset mid IF_RD: deassert `rst_n` at cnt = 5 → all outputs 0 immediately. After release, `if_req` at 0x100 completes after 17 cycles with `if_data` = RAM[0x100..0x10F].
- Word load at 0x2002 with RAM = 11 22 33 44 → `ls_done` 5 cycles after grant, `ls_rdata` = 0x44332211. Half load at the same address → 0x00002211.
- Byte store 0xAB to 0x30000 (not full) → one cycle with `mem_wr` = 1, `mem_a` = 0x30000, `mem_dout` = 0xAB. `ls_done` follows next cycle.
- `ls_req` and `if_req` held continuously with `LS_STREAK` = 4 → grant sequence LS, LS, LS, LS, IF, LS…
- `flush` at cnt = 3 of an IF line → no `if_done` and return to IDLE. The same flush during a word store → the store completes all 4 bytes and `ls_done` pulses.
- `MEM_IO_GUARD_EN`: store to 0x30004 with `io_buffer_full` = 1 for 10 cycles → `mem_wr` stays 0 throughout, and a pending IF is served meanwhile. The store is granted on the first cycle `io_buffer_full` = 0.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: byte-serial memory controller arbitrating I-cache line fetches and LSB loads/stores.
// Optional IO back-pressure guard is compiled in when MEM_IO_GUARD_EN is defined.
module mem_arb #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int LS_STREAK  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_data,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [1:0]              ls_size,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int CNT_W  = $clog2(LINE_BYTES) + 1;
  localparam int STK_W  = $clog2(LS_STREAK + 1);
  localparam int LINE_W = 8 * LINE_BYTES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IF_RD = 3'd1,
    LS_RD = 3'd2,
    LS_WR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CNT_W-1:0]  len_r, len_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic [31:0]       wdata_r, wdata_s;
  logic              io_r, io_s;
  logic              done_if_r, done_if_s;
  logic [STK_W-1:0]  streak_r, streak_s;
  logic [LINE_W-1:0] buf_r, buf_s;
  logic [LINE_W-1:0] line_r, line_s;
  logic [31:0]       rdata_r, rdata_s;

  logic ls_ok_s;
  logic ls_io_s;
  logic if_first_s;
  logic grant_if_s;
  logic grant_ls_s;

  function automatic logic [CNT_W-1:0] ls_len(input logic [1:0] size);
    case (size)
      2'd0:    ls_len = CNT_W'(1);
      2'd1:    ls_len = CNT_W'(2);
      default: ls_len = CNT_W'(4);
    endcase
  endfunction

  function automatic logic in_io(input logic [ADDR_W-1:0] a);
    in_io = (a[17:16] == 2'b11);
  endfunction

`ifdef MEM_IO_GUARD_EN
  // IO stores wait while the IO FIFO is full; IO loads are commit-time and must not be dropped.
  assign ls_ok_s = ls_req && !(ls_we && in_io(ls_addr) && io_buffer_full);
  assign ls_io_s = in_io(ls_addr);
`else
  logic io_full_unused_s;
  assign ls_ok_s          = ls_req;
  assign ls_io_s          = 1'b0;
  assign io_full_unused_s = io_buffer_full;
`endif

  assign if_first_s = if_req && (streak_r >= STK_W'(LS_STREAK));
  assign grant_if_s = if_req && (if_first_s || !ls_ok_s);
  assign grant_ls_s = ls_ok_s && !grant_if_s;

  // Next-state and datapath update; everything holds while rdy is low.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    len_s     = len_r;
    base_s    = base_r;
    wdata_s   = wdata_r;
    io_s      = io_r;
    done_if_s = done_if_r;
    streak_s  = streak_r;
    buf_s     = buf_r;
    line_s    = line_r;
    rdata_s   = rdata_r;
    if (!rdy) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_if_s) begin
            state_s  = IF_RD;
            base_s   = if_addr;
            len_s    = CNT_W'(LINE_BYTES);
            cnt_s    = '0;
            buf_s    = '0;
            io_s     = 1'b0;
            streak_s = '0;
          end else if (grant_ls_s) begin
            state_s  = ls_we ? LS_WR : LS_RD;
            base_s   = ls_addr;
            len_s    = ls_len(ls_size);
            wdata_s  = ls_wdata;
            cnt_s    = '0;
            buf_s    = '0;
            io_s     = ls_io_s;
            streak_s = if_req ? (streak_r + STK_W'(1)) : '0;
          end else begin
            state_s = IDLE;
          end
        end
        IF_RD, LS_RD: begin
          if (flush && !((state_r == LS_RD) && io_r)) begin
            state_s = IDLE;
          end else begin
            // mem_din lags mem_a by one cycle, so count cnt holds byte cnt-1.
            if (cnt_r != '0) begin
              buf_s[{cnt_r - CNT_W'(1), 3'b000} +: 8] = mem_din;
            end else begin
              buf_s = buf_r;
            end
            if (cnt_r == len_r) begin
              state_s   = DONE;
              done_if_s = (state_r == IF_RD);
              if (state_r == IF_RD) begin
                line_s = buf_s;
              end else begin
                rdata_s = buf_s[31:0];
              end
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end
        end
        LS_WR: begin
          if (cnt_r == (len_r - CNT_W'(1))) begin
            state_s   = DONE;
            done_if_s = 1'b0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Memory port drive; quiet in IDLE/DONE so no spurious IO access is issued.
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    case (state_r)
      IF_RD, LS_RD: begin
        if (!rdy && (cnt_r != '0)) begin
          mem_a = base_r + ADDR_W'(cnt_r - CNT_W'(1));
        end else if (cnt_r < len_r) begin
          mem_a = base_r + ADDR_W'(cnt_r);
        end else begin
          mem_a = '0;
        end
      end
      LS_WR: begin
        mem_a    = base_r + ADDR_W'(cnt_r);
        mem_wr   = rdy;
        mem_dout = wdata_r[{cnt_r[1:0], 3'b000} +: 8];
      end
      default: begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
      end
    endcase
  end

  // State, burst and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      len_r     <= '0;
      base_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      io_r      <= 1'b0;
      done_if_r <= 1'b0;
      streak_r  <= '0;
      buf_r     <= '0;
      line_r    <= '0;
      rdata_r   <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      len_r     <= len_s;
      base_r    <= base_s;
      wdata_r   <= wdata_s;
      io_r      <= io_s;
      done_if_r <= done_if_s;
      streak_r  <= streak_s;
      buf_r     <= buf_s;
      line_r    <= line_s;
      rdata_r   <= rdata_s;
    end
  end

  assign if_done  = (state_r == DONE) && done_if_r;
  assign ls_done  = (state_r == DONE) && !done_if_r;
  assign if_data  = line_r;
  assign ls_rdata = rdata_r;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized transactions
// checked against a byte-array memory model and transaction-level latency rules.
module tb_mem_arb;

  localparam int LB        = 16;
  localparam int LS_STREAK = 4;

  logic clk = 1'b0;
  logic rst_n, rdy, flush, if_req, ls_req, ls_we, io_buffer_full;
  logic if_done, ls_done, mem_wr;
  logic [31:0] if_addr, ls_addr, ls_wdata, ls_rdata, mem_a;
  logic [1:0] ls_size;
  logic [8*LB-1:0] if_data;
  logic [7:0] mem_din, mem_dout;

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_count     = 0;

  logic [7:0] dev_mem [0:65535];
  bit         dev_vld [0:65535];
  logic [7:0] ref_mem [0:65535];

  mem_arb #(.LINE_BYTES(LB), .ADDR_W(32), .LS_STREAK(LS_STREAK)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h2002: return 8'h11;
      16'h2003: return 8'h22;
      16'h2004: return 8'h33;
      16'h2005: return 8'h44;
      default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endcase
  endfunction

  // External RAM: read data reflects the previous cycle's address
  always @(posedge clk) begin
    mem_din <= dev_vld[mem_a[15:0]] ? dev_mem[mem_a[15:0]] : init_byte(mem_a[15:0]);
    if (mem_wr) begin
      dev_mem[mem_a[15:0]] <= mem_dout;
      dev_vld[mem_a[15:0]] <= 1'b1;
      wr_count <= wr_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input bit is_if, input logic [1:0] size);
    if (is_if) return LB;
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [127:0] ref_read(input logic [31:0] a, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[16'(a + 32'(i))];
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) ref_mem[16'(a + 32'(i))] = d[8*i +: 8];
  endtask

  // One transaction with rdy randomly dropped rdy_pct percent of cycles.
  task automatic run_req(input string tag, input bit is_if, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input int rdy_pct);
    int n, hi, wr0;
    bit seen;
    n = nbytes(is_if, size);
    hi = 0;
    seen = 1'b0;
    wr0 = wr_count;
    if (is_if) begin
      if_addr = addr; if_req = 1'b1;
    end else begin
      ls_addr = addr; ls_we = we; ls_size = size; ls_wdata = wd; ls_req = 1'b1;
    end
    for (int c = 0; c < 400 && !seen; c++) begin
      rdy = ($urandom_range(99) >= rdy_pct);
      step();
      if (rdy) hi++;
      seen = is_if ? if_done : ls_done;
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    check({tag, "_done"}, seen, 1);
    check({tag, "_lat"}, hi - 1, we ? n : n + 1);
    if (is_if) check({tag, "_line"}, if_data, ref_read(addr, n));
    else if (!we) check({tag, "_rdata"}, ls_rdata, ref_read(addr, n));
    else ref_write(addr, wd, n);
    rdy = 1'b1;
    step();
    check({tag, "_pulse"}, is_if ? if_done : ls_done, 0);
    if (we) check({tag, "_wrcnt"}, wr_count - wr0, n);
  endtask

  initial begin
    bit seen;
    int wr0, got, streak, kind;
    bit exp_seq [10];
    bit got_seq [10];

    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    ls_we = 1'b0; ls_size = 2'd0; if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
    io_buffer_full = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

    repeat (2) @(posedge clk);
    #1;
    check("rst_if_done", if_done, 0);
    check("rst_ls_done", ls_done, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_if_data", if_data, 0);
    check("rst_ls_rdata", ls_rdata, 0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a line fetch
    if_addr = 32'h100; if_req = 1'b1;
    step();
    repeat (5) step();
    check("burst_a", mem_a, 32'h105);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_a", mem_a, 0);
    check("mid_rst_if_done", if_done, 0);
    check("mid_rst_if_data", if_data, 0);
    if_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_req("line100", 1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 0);

    run_req("ldw", 1'b0, 1'b0, 2'd2, 32'h2002, 32'h0, 0);
    check("ldw_val", ls_rdata, 32'h44332211);
    run_req("ldh", 1'b0, 1'b0, 2'd1, 32'h2002, 32'h0, 0);
    check("ldh_val", ls_rdata, 32'h00002211);

    // Byte store: one write cycle, done the cycle after
    ls_addr = 32'h30000; ls_we = 1'b1; ls_size = 2'd0; ls_wdata = 32'h000000AB; ls_req = 1'b1;
    step();
    check("stb_wr", mem_wr, 1);
    check("stb_a", mem_a, 32'h30000);
    check("stb_dout", mem_dout, 8'hAB);
    check("stb_early_done", ls_done, 0);
    step();
    check("stb_done", ls_done, 1);
    check("stb_wr_end", mem_wr, 0);
    ls_req = 1'b0; ls_we = 1'b0;
    step();
    check("stb_pulse", ls_done, 0);
    ref_write(32'h30000, 32'h000000AB, 1);
    run_req("ldb_io", 1'b0, 1'b0, 2'd0, 32'h30000, 32'h0, 0);

    // Flush at cnt = 3 of a line fetch
    if_addr = 32'h1040; if_req = 1'b1;
    step();
    repeat (3) step();
    check("fl_cnt3_a", mem_a, 32'h1043);
    flush = 1'b1; if_req = 1'b0;
    step();
    flush = 1'b0;
    check("fl_idle_a", mem_a, 0);
    seen = 1'b0;
    repeat (25) begin
      step();
      if (if_done) seen = 1'b1;
    end
    check("fl_no_done", seen, 0);
    check("fl_if_data_held", if_data, ref_read(32'h100, LB));

    // Flush during a word store must not abort it
    wr0 = wr_count;
    ls_addr = 32'h1200; ls_we = 1'b1; ls_size = 2'd2; ls_wdata = 32'hCAFEBABE; ls_req = 1'b1;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (ls_done) seen = 1'b1;
      else step();
    end
    check("flst_done", seen, 1);
    check("flst_wrcnt", wr_count - wr0, 4);
    ls_req = 1'b0; ls_we = 1'b0;
    step();
    ref_write(32'h1200, 32'hCAFEBABE, 4);
    run_req("flst_rb", 1'b0, 1'b0, 2'd2, 32'h1200, 32'h0, 0);

    // Both clients held: IF gets every (LS_STREAK+1)th grant
    streak = 0;
    for (int k = 0; k < 10; k++) begin
      if (streak == LS_STREAK) begin
        exp_seq[k] = 1'b1; streak = 0;
      end else begin
        exp_seq[k] = 1'b0; streak++;
      end
      got_seq[k] = 1'b0;
    end
    if_addr = 32'h1000; ls_addr = 32'h1010; ls_we = 1'b0; ls_size = 2'd0;
    if_req = 1'b1; ls_req = 1'b1; got = 0;
    for (int c = 0; c < 500 && got < 10; c++) begin
      step();
      if (if_done) begin
        got_seq[got] = 1'b1; got++;
      end else if (ls_done) begin
        got_seq[got] = 1'b0; got++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    step();
    check("arb_count", got, 10);
    for (int k = 0; k < 10; k++) check($sformatf("arb_%0d", k), got_seq[k], exp_seq[k]);

`ifdef MEM_IO_GUARD_EN
    begin : io_guard
      bit wr_seen;
      io_buffer_full = 1'b1;
      ls_addr = 32'h30004; ls_we = 1'b1; ls_size = 2'd0; ls_wdata = 32'h0000005A; ls_req = 1'b1;
      if_addr = 32'h1080; if_req = 1'b1;
      seen = 1'b0; wr_seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        step();
        if (mem_wr) wr_seen = 1'b1;
        if (if_done) seen = 1'b1;
      end
      if_req = 1'b0;
      repeat (3) begin
        step();
        if (mem_wr) wr_seen = 1'b1;
      end
      check("io_if_served", seen, 1);
      check("io_no_wr", wr_seen, 0);
      io_buffer_full = 1'b0;
      step();
      check("io_wr", mem_wr, 1);
      check("io_a", mem_a, 32'h30004);
      step();
      check("io_done", ls_done, 1);
      ls_req = 1'b0; ls_we = 1'b0;
      step();
      ref_write(32'h30004, 32'h0000005A, 1);
    end
`endif

    // Randomized single-client traffic with rdy stalls
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(2));
      if (kind == 0)
        run_req("rnd_if", 1'b1, 1'b0, 2'd0, 32'h1000 + ($urandom_range(15) << 4), 32'h0, 25);
      else
        run_req((kind == 2) ? "rnd_st" : "rnd_ld", 1'b0, kind == 2, 2'($urandom_range(3)),
                32'h1000 + $urandom_range(255), $urandom, 25);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
